// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory / MMIO responder: register map,
// STATUS bit layout and the console serializer state encoding.
package dmem_pkg;

  localparam logic [31:0] ADDR_TXDATA = 32'hFFFF_0000;
  localparam logic [31:0] ADDR_STATUS = 32'hFFFF_0004;
  localparam logic [31:0] ADDR_CYCLES = 32'hFFFF_0008;

  localparam int unsigned ST_FULL    = 0;
  localparam int unsigned ST_EMPTY   = 1;
  localparam int unsigned ST_OVF     = 2;
  localparam int unsigned ST_BUSY    = 3;
  localparam int unsigned ST_CNT_LSB = 4;
  localparam int unsigned ST_CNT_W   = 4;

  typedef enum logic [1:0] {
    SER_IDLE  = 2'd0,
    SER_START = 2'd1,
    SER_DATA  = 2'd2,
    SER_STOP  = 2'd3
  } ser_state_e;

  // Word-granular register match; the byte offset within a word is ignored.
  function automatic logic word_match(input logic [31:0] addr, input logic [31:0] base);
    return (addr & ~32'h3) == base;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer for the console line: pulls one byte per frame from a
// valid/ready source and drives start, eight data bits LSB first, stop.
module uart_tx_serializer
  import dmem_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  ser_state_e        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              baud_end_c;

  assign baud_end_c = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  // Next-state logic; ready is asserted only on edges that start a new frame.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    ready   = 1'b0;
    case (state_q)
      SER_IDLE: begin
        ready = 1'b1;
        tx_d  = 1'b1;
        if (valid) begin
          state_d = SER_START;
          shift_d = data;
          baud_d  = '0;
          tx_d    = 1'b0;
        end
      end
      SER_START: begin
        if (baud_end_c) begin
          state_d = SER_DATA;
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      SER_DATA: begin
        if (baud_end_c) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = SER_STOP;
            bit_d   = 3'd0;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      SER_STOP: begin
        if (baud_end_c) begin
          ready  = 1'b1;
          baud_d = '0;
          if (valid) begin
            state_d = SER_START;
            shift_d = data;
            tx_d    = 1'b0;
          end else begin
            state_d = SER_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = SER_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SER_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != SER_IDLE);

endmodule

// File: rtl/dmem_mmio_responder.sv
// CPU data-memory responder: word RAM plus console MMIO (TX FIFO, STATUS,
// optional cycle counter enabled by DMEM_CYCLE_COUNTER_EN).
module dmem_mmio_responder
  import dmem_pkg::*;
#(
  parameter int unsigned RAM_WORDS    = 64,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] memaddr,
  input  logic [31:0] memwritedata,
  output logic [31:0] memreaddata,
  output logic        tx
);

  localparam int unsigned RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

  logic              sel_ram_c, sel_tx_c, sel_status_c, sel_cycles_c;
  logic [RAM_AW-1:0] ram_idx_c;

  assign sel_ram_c    = (memaddr[31:16] == 16'h0000) && (32'(memaddr[15:2]) < RAM_WORDS);
  assign sel_tx_c     = word_match(memaddr, ADDR_TXDATA);
  assign sel_status_c = word_match(memaddr, ADDR_STATUS);
  assign sel_cycles_c = word_match(memaddr, ADDR_CYCLES);
  assign ram_idx_c    = memaddr[RAM_AW+1:2];

  // Data RAM: write-first-edge, read-old combinationally; never reset.
  logic [31:0] ram_q [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (memwrite && sel_ram_c) begin
      ram_q[ram_idx_c] <= memwritedata;
    end
  end

  logic [7:0]       fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             full_c, empty_c, push_req_c, push_c, pop_c;
  logic             ser_ready_c, ser_busy_c, ser_valid_c;

  assign full_c      = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_c     = (count_q == '0);
  assign ser_valid_c = !empty_c;
  assign pop_c       = ser_ready_c && ser_valid_c;
  assign push_req_c  = memwrite && sel_tx_c;
  // A full FIFO still takes the byte when the serializer drains one on the same edge.
  assign push_c      = push_req_c && (!full_c || pop_c);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_c) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (memwrite && sel_status_c) begin
      ovf_d = 1'b0;
    end
    if (push_req_c && full_c && !pop_c) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_q[wr_ptr_q] <= memwritedata[7:0];
    end
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk  (clk),
    .reset(reset),
    .valid(ser_valid_c),
    .data (fifo_q[rd_ptr_q]),
    .ready(ser_ready_c),
    .tx   (tx),
    .busy (ser_busy_c)
  );

  logic [31:0] cycles_rd_c;

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycles_q, cycles_d;

  assign cycles_d = (memwrite && sel_cycles_c) ? memwritedata : cycles_q + 32'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycles_q <= 32'd0;
    end else begin
      cycles_q <= cycles_d;
    end
  end

  assign cycles_rd_c = cycles_q;
`else
  assign cycles_rd_c = 32'd0;
`endif

  logic [31:0] status_c;

  always_comb begin
    status_c                           = 32'd0;
    status_c[ST_FULL]                  = full_c;
    status_c[ST_EMPTY]                 = empty_c;
    status_c[ST_OVF]                   = ovf_q;
    status_c[ST_BUSY]                  = ser_busy_c;
    status_c[ST_CNT_LSB +: ST_CNT_W]   = ST_CNT_W'(count_q);
  end

  // Zero-latency read mux; TXDATA and unmapped space read as zero.
  always_comb begin
    memreaddata = 32'd0;
    if (sel_ram_c) begin
      memreaddata = ram_q[ram_idx_c];
    end else if (sel_status_c) begin
      memreaddata = status_c;
    end else if (sel_cycles_c) begin
      memreaddata = cycles_rd_c;
    end
  end

endmodule
